// File: rtl/bcd_countdown4_pkg.sv
// =============================================================================
// bcd_countdown4_pkg : shared BCD constants, digit type and load sanitiser
// Rev 1.0
// =============================================================================
`default_nettype none

package bcd_countdown4_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX  = 4'd9;
  localparam digit_t BCD_ZERO = 4'd0;

  // Out-of-range nibbles saturate to the largest decimal digit.
  function automatic digit_t bcd_sat(input digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// =============================================================================
// bcd_down_digit : one down-counting BCD digit with load, wrap-to-9 and borrow
// Rev 1.0
// =============================================================================
`default_nettype none

module bcd_down_digit
  import bcd_countdown4_pkg::*;
(
  input  logic   CLK,
  input  logic   CLR,
  input  logic   i_load,
  input  digit_t i_load_val,
  input  logic   i_bin,
  output digit_t o_q,
  output logic   o_bout
);

  digit_t r_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_q <= BCD_ZERO;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_bin) begin
      r_q <= (r_q == BCD_ZERO) ? BCD_MAX : (r_q - 4'd1);
    end
  end

  assign o_q    = r_q;
  assign o_bout = i_bin && (r_q == BCD_ZERO);

endmodule

`default_nettype wire

// File: rtl/bcd_countdown4.sv
// =============================================================================
// bcd_countdown4 : cascadable NDIG-digit BCD down counter with load/reload
// Rev 1.0
// =============================================================================
`default_nettype none

module bcd_countdown4
  import bcd_countdown4_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [4*NDIG-1:0]   D,
  input  logic                LOAD,
  input  logic                ENP,
  input  logic                ENT,
  output logic [4*NDIG-1:0]   COUT,
  output logic                BRW,
  output logic                DONE,
  output logic                ERR
);

  logic [4*NDIG-1:0] r_reload;
  logic              r_done;
  logic              r_err;

  logic [4*NDIG-1:0] w_count;
  logic [4*NDIG-1:0] w_dsan;
  logic [NDIG-1:0]   w_bad;
  logic [NDIG:0]     w_bin;
  logic              w_cnt;
  logic              w_zero;
  logic              w_one;
  logic              w_dig_load;
  logic [4*NDIG-1:0] w_dig_val;

  assign w_cnt  = LOAD && ENP && ENT;
  assign w_zero = (w_count == '0);
  assign w_one  = (w_count == (4*NDIG)'(1));

  // Auto-reload rides the digit load path so the terminal step is one edge.
  assign w_dig_load = !LOAD || ((AUTO_RELOAD != 0) && w_cnt && w_zero);
  assign w_dig_val  = !LOAD ? w_dsan : r_reload;
  assign w_bin[0]   = w_cnt;

  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_digit
      assign w_dsan[4*i +: 4] = bcd_sat(D[4*i +: 4]);
      assign w_bad[i]         = (D[4*i +: 4] > BCD_MAX);

      bcd_down_digit u_digit (
        .CLK        (CLK),
        .CLR        (CLR),
        .i_load     (w_dig_load),
        .i_load_val (w_dig_val[4*i +: 4]),
        .i_bin      (w_bin[i]),
        .o_q        (w_count[4*i +: 4]),
        .o_bout     (w_bin[i+1])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_reload <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_cnt && w_one;
      if (!LOAD) begin
        r_reload <= w_dsan;
        r_err    <= |w_bad;
      end
    end
  end

  assign COUT = w_count;
  assign BRW  = ENT && w_zero;
  assign DONE = r_done;
  assign ERR  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown4.sv
// =============================================================================
// tb_bcd_countdown4 : directed checks for wrap (AUTO_RELOAD=0) and reload (=1)
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_bcd_countdown4;

  logic        CLK;
  logic        CLR;
  logic [15:0] D;
  logic        LOAD;
  logic        ENP;
  logic        ENT;
  logic [15:0] w_cout0, w_cout1;
  logic        w_brw0, w_brw1;
  logic        w_done0, w_done1;
  logic        w_err0, w_err1;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_countdown4 #(.NDIG(4), .AUTO_RELOAD(0)) u_dut_wrap (
    .CLK(CLK), .CLR(CLR), .D(D), .LOAD(LOAD), .ENP(ENP), .ENT(ENT),
    .COUT(w_cout0), .BRW(w_brw0), .DONE(w_done0), .ERR(w_err0)
  );

  bcd_countdown4 #(.NDIG(4), .AUTO_RELOAD(1)) u_dut_rld (
    .CLK(CLK), .CLR(CLR), .D(D), .LOAD(LOAD), .ENP(ENP), .ENT(ENT),
    .COUT(w_cout1), .BRW(w_brw1), .DONE(w_done1), .ERR(w_err1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR = 1'b0; D = 16'h0000; LOAD = 1'b1; ENP = 1'b0; ENT = 1'b0;
    #2;
    chk("rst_cout", 32'(w_cout0), 32'h0000);
    chk("rst_done", 32'(w_done0), 32'h0);
    chk("rst_err",  32'(w_err0),  32'h0);
    chk("rst_brw_ent0", 32'(w_brw0), 32'h0);
    ENT = 1'b1; #1;
    chk("rst_brw_ent1", 32'(w_brw0), 32'h1);
    step();
    chk("rst_hold_cout", 32'(w_cout0), 32'h0000);
    CLR = 1'b1; ENT = 1'b0;

    // Load 3 then count to zero
    D = 16'h0003; LOAD = 1'b0; step();
    chk("ld3_cout", 32'(w_cout0), 32'h0003);
    LOAD = 1'b1; ENP = 1'b1; ENT = 1'b1;
    step(); chk("cnt_2", 32'(w_cout0), 32'h0002);
    chk("cnt_2_done", 32'(w_done0), 32'h0);
    step(); chk("cnt_1", 32'(w_cout0), 32'h0001);
    step(); chk("cnt_0", 32'(w_cout0), 32'h0000);
    chk("cnt_0_done", 32'(w_done0), 32'h1);
    chk("cnt_0_brw",  32'(w_brw0),  32'h1);
    ENP = 1'b0; step();
    chk("hold0_cout", 32'(w_cout0), 32'h0000);
    chk("hold0_done", 32'(w_done0), 32'h0);

    // Digit borrow across three digits
    D = 16'h1000; LOAD = 1'b0; step();
    LOAD = 1'b1; ENP = 1'b1; step();
    chk("borrow_0999", 32'(w_cout0), 32'h0999);
    chk("borrow_brw",  32'(w_brw0),  32'h0);

    // Terminal behaviour for both parameterisations
    D = 16'h0250; LOAD = 1'b0; step();
    LOAD = 1'b1;
    for (int i = 0; i < 250; i++) step();
    chk("term_zero_wrap", 32'(w_cout0), 32'h0000);
    chk("term_zero_rld",  32'(w_cout1), 32'h0000);
    chk("term_done_rld",  32'(w_done1), 32'h1);
    step();
    chk("term_wrap_9999", 32'(w_cout0), 32'h9999);
    chk("term_rld_0250",  32'(w_cout1), 32'h0250);
    chk("term_done_off",  32'(w_done0), 32'h0);
    step();
    chk("after_wrap_9998", 32'(w_cout0), 32'h9998);

    // Zero reached by load gives no DONE; next count wraps
    D = 16'h0000; LOAD = 1'b0; step();
    chk("ld0_done", 32'(w_done0), 32'h0);
    LOAD = 1'b1; step();
    chk("ld0_wrap", 32'(w_cout0), 32'h9999);
    chk("ld0_rld",  32'(w_cout1), 32'h0000);

    // Invalid load sanitising and sticky ERR
    D = 16'h12AF; LOAD = 1'b0; step();
    chk("bad_cout", 32'(w_cout0), 32'h1299);
    chk("bad_err",  32'(w_err0),  32'h1);
    LOAD = 1'b1; step();
    chk("bad_cnt",      32'(w_cout0), 32'h1298);
    chk("bad_err_hold", 32'(w_err0),  32'h1);
    D = 16'h0005; LOAD = 1'b0; step();
    chk("good_cout", 32'(w_cout0), 32'h0005);
    chk("good_err",  32'(w_err0),  32'h0);

    // Enables and priority
    D = 16'h0000; step();
    LOAD = 1'b1; ENT = 1'b0; ENP = 1'b1; step();
    chk("ent0_hold", 32'(w_cout0), 32'h0000);
    chk("ent0_brw",  32'(w_brw0),  32'h0);
    ENT = 1'b1; ENP = 1'b0; step();
    chk("enp0_hold", 32'(w_cout0), 32'h0000);
    chk("enp0_brw",  32'(w_brw0),  32'h1);
    D = 16'h0042; LOAD = 1'b0; ENP = 1'b1; step();
    chk("ld_prio", 32'(w_cout0), 32'h0042);

    // Asynchronous reset between edges
    LOAD = 1'b1; CLR = 1'b0; #1;
    chk("clr_cout", 32'(w_cout0), 32'h0000);
    chk("clr_done", 32'(w_done0), 32'h0);
    chk("clr_brw",  32'(w_brw0),  32'h1);
    CLR = 1'b1; step();
    chk("clr_wrap", 32'(w_cout0), 32'h9999);
    chk("clr_rld",  32'(w_cout1), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
